// File: rtl/ham_pkg.sv
// ---------------------------------------------------------------------------
// ham_pkg
// Shared definitions for the (17,12) Hamming SEC decoder and its arbiter.
//   HAM_N / HAM_K / SYN_W : codeword, data and syndrome widths
//   state_e               : arbiter sequencing states (IDLE=0, DEC=1, OUT=2)
//   ham_res_t             : one decoded result (data, syndrome, flags)
//   syn_mask()            : codeword bits that feed syndrome bit k
//   ham_extract()         : data bits pulled out of a (corrected) codeword
// ---------------------------------------------------------------------------
package ham_pkg;

   localparam int HAM_N = 17;
   localparam int HAM_K = 12;
   localparam int SYN_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   typedef struct packed {
      logic [HAM_K-1:0] data;
      logic [SYN_W-1:0] syn;
      logic             corr;
      logic             unc;
   } ham_res_t;

   // Codeword bit i sits at Hamming position i+1; syndrome bit k covers
   // every position whose binary index has bit k set.
   function automatic logic [HAM_N-1:0] syn_mask(input int k);
      logic [HAM_N-1:0] m;
      for (int i = 0; i < HAM_N; i++) begin
         m[i] = (((i + 1) >> k) & 1) != 0;
      end
      return m;
   endfunction

   // Non-parity positions 3,5,6,7,9..15,17, least significant first.
   function automatic logic [HAM_K-1:0] ham_extract(input logic [HAM_N-1:0] cw);
      return {cw[16], cw[14:8], cw[6:4], cw[2]};
   endfunction

endpackage

// File: rtl/ham17_dec.sv
// ---------------------------------------------------------------------------
// ham17_dec
// Purely combinational (17,12) Hamming single-error-correcting decoder.
// Ports:
//   codeword_i [16:0] : received codeword
//   data_o     [11:0] : data bits after correction
//   syn_o      [4:0]  : syndrome
//   corr_o            : a single bit was flipped (syndrome 1..17)
//   unc_o             : syndrome points outside the codeword (18..31)
// ---------------------------------------------------------------------------
module ham17_dec
   import ham_pkg::*;
(
   input  logic [HAM_N-1:0] codeword_i,
   output logic [HAM_K-1:0] data_o,
   output logic [SYN_W-1:0] syn_o,
   output logic             corr_o,
   output logic             unc_o
);

   // One-hot flip vector: at most one position matches a non-zero syndrome.
   logic [HAM_N-1:0] flip;

   genvar gi;
   generate
      for (gi = 0; gi < SYN_W; gi++) begin : g_syn
         assign syn_o[gi] = ^(codeword_i & syn_mask(gi));
      end
      for (gi = 0; gi < HAM_N; gi++) begin : g_flip
         assign flip[gi] = (syn_o == SYN_W'(gi + 1));
      end
   endgenerate

   assign corr_o = |flip;
   assign unc_o  = (syn_o > SYN_W'(HAM_N));
   assign data_o = ham_extract(codeword_i ^ flip);

endmodule

// File: rtl/ham_dec_arb.sv
// ---------------------------------------------------------------------------
// ham_dec_arb
// Two-requester round-robin arbiter and sequencer around one shared ham17_dec.
// Each accepted codeword walks IDLE -> DEC -> OUT; the registered result is
// held on the output handshake until the consumer takes it.
// Ports:
//   clk, reset_n                : clock, synchronous active-low reset
//   in0_valid/in0_codeword/in0_ready : channel 0 codeword handshake
//   in1_valid/in1_codeword/in1_ready : channel 1 codeword handshake
//   out_valid/out_ready         : result handshake
//   out_data, out_id, out_syn, out_corr, out_unc : registered result fields
//   cnt_clr                     : synchronous clear of both counters
//   corr_cnt0, corr_cnt1        : saturating corrected-error counts
// ---------------------------------------------------------------------------
module ham_dec_arb
   import ham_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in0_valid,
   input  logic [HAM_N-1:0] in0_codeword,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [HAM_N-1:0] in1_codeword,
   output logic             in1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [HAM_K-1:0] out_data,
   output logic             out_id,
   output logic [SYN_W-1:0] out_syn,
   output logic             out_corr,
   output logic             out_unc,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_cnt0,
   output logic [CNT_W-1:0] corr_cnt1
);

   state_e           state_q, state_d;
   logic             rr_q, rr_d;
   logic [HAM_N-1:0] cw_q, cw_d;
   logic             id_q, id_d;
   ham_res_t         res_q;
   logic             gnt0, gnt1;
   logic             gnt_id;

   logic [HAM_K-1:0] dec_data;
   logic [SYN_W-1:0] dec_syn;
   logic             dec_corr;
   logic             dec_unc;
   ham_res_t         dec_res;

   logic [1:0][CNT_W-1:0] cnt_all;

   // The decoder only ever sees the captured codeword, so producers may
   // change their inputs freely once the accept cycle is over.
   ham17_dec u_dec (
      .codeword_i (cw_q),
      .data_o     (dec_data),
      .syn_o      (dec_syn),
      .corr_o     (dec_corr),
      .unc_o      (dec_unc)
   );

   assign dec_res = {dec_data, dec_syn, dec_corr, dec_unc};

   // -----------------------------------------------------------------------
   // Next-state, grant and capture logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cw_d    = cw_q;
      id_d    = id_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      gnt_id  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in0_valid || in1_valid) begin
               // Contention goes to the pointer; a lone requester always wins.
               gnt_id  = (in0_valid && in1_valid) ? rr_q : in1_valid;
               gnt0    = ~gnt_id;
               gnt1    = gnt_id;
               cw_d    = gnt_id ? in1_codeword : in0_codeword;
               id_d    = gnt_id;
               rr_d    = ~gnt_id;
               state_d = ST_DEC;
            end
         end
         ST_DEC: begin
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Readies are masked while reset is asserted so nothing is "accepted"
   // by an upstream producer on a cycle the block is about to discard.
   assign in0_ready = reset_n & gnt0;
   assign in1_ready = reset_n & gnt1;

   // -----------------------------------------------------------------------
   // State and result registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         rr_q    <= 1'b0;
         cw_q    <= '0;
         id_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cw_q    <= cw_d;
         id_q    <= id_d;
         if (state_q == ST_DEC) begin
            res_q <= dec_res;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Per-channel saturating corrected-error counters
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             hit;

         // Only the DEC cycle of this channel's word may bump the count.
         assign hit = (state_q == ST_DEC) && dec_corr && (id_q == 1'(gi));

         always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
               cnt_d = '0;
            end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_all[gi] = cnt_q;
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = res_q.data;
   assign out_syn   = res_q.syn;
   assign out_corr  = res_q.corr;
   assign out_unc   = res_q.unc;
   assign out_id    = id_q;
   assign corr_cnt0 = cnt_all[0];
   assign corr_cnt1 = cnt_all[1];

endmodule

// File: tb/tb_ham_dec_arb.sv
// ---------------------------------------------------------------------------
// tb_ham_dec_arb
// Scoreboard bench: a monitor predicts grants, results and counter values
// from the decoding rules and compares against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_ham_dec_arb;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = 3;

   logic        clk          = 1'b0;
   logic        reset_n      = 1'b0;
   logic        in0_valid    = 1'b0;
   logic [16:0] in0_codeword = '0;
   logic        in0_ready;
   logic        in1_valid    = 1'b0;
   logic [16:0] in1_codeword = '0;
   logic        in1_ready;
   logic        out_valid;
   logic        out_ready    = 1'b1;
   logic [11:0] out_data;
   logic        out_id;
   logic [4:0]  out_syn;
   logic        out_corr;
   logic        out_unc;
   logic        cnt_clr      = 1'b0;
   logic [CNT_W-1:0] corr_cnt0;
   logic [CNT_W-1:0] corr_cnt1;

   always #5 clk = ~clk;

   ham_dec_arb #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in0_valid    (in0_valid),
      .in0_codeword (in0_codeword),
      .in0_ready    (in0_ready),
      .in1_valid    (in1_valid),
      .in1_codeword (in1_codeword),
      .in1_ready    (in1_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_id       (out_id),
      .out_syn      (out_syn),
      .out_corr     (out_corr),
      .out_unc      (out_unc),
      .cnt_clr      (cnt_clr),
      .corr_cnt0    (corr_cnt0),
      .corr_cnt1    (corr_cnt1)
   );

   typedef struct {
      logic [11:0] data;
      logic        id;
      logic [4:0]  syn;
      logic        corr;
      logic        unc;
   } exp_t;

   exp_t sb_q[$];
   int   grant_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: the syndrome of a word is the XOR of the positions of
   // its set bits; a syndrome inside 1..17 names the position to flip.
   function automatic exp_t ref_dec(input logic [16:0] cw, input logic id);
      exp_t        e;
      int          s = 0;
      int          k = 0;
      logic [16:0] c = cw;
      for (int i = 0; i < 17; i++) if (cw[i]) s = s ^ (i + 1);
      e.id   = id;
      e.syn  = 5'(s);
      e.corr = 1'b0;
      e.unc  = 1'b0;
      if (s >= 1 && s <= 17) begin
         c[s-1] = ~c[s-1];
         e.corr = 1'b1;
      end else if (s > 17) begin
         e.unc = 1'b1;
      end
      e.data = '0;
      for (int p = 1; p <= 17; p++) begin
         if ((p & (p - 1)) != 0) begin
            e.data[k] = c[p-1];
            k++;
         end
      end
      return e;
   endfunction

   function automatic logic [16:0] enc(input logic [11:0] d);
      logic [16:0] cw = '0;
      int k = 0;
      int s = 0;
      for (int p = 1; p <= 17; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[k];
            if (d[k]) s = s ^ p;
            k++;
         end
      end
      for (int j = 0; j < 5; j++) if (((s >> j) & 1) != 0) cw[(1 << j) - 1] = 1'b1;
      return cw;
   endfunction

   function automatic logic [16:0] rand_cw();
      logic [16:0] cw = enc(12'($urandom));
      int mode = $urandom_range(0, 3);
      if (mode == 1 || mode == 2) cw[$urandom_range(0, 16)] ^= 1'b1;
      if (mode == 2) cw[$urandom_range(0, 16)] ^= 1'b1;
      if (mode == 3) cw = 17'($urandom);
      return cw;
   endfunction

   function automatic logic [16:0] corr_cw();
      logic [16:0] cw = enc(12'($urandom));
      cw[$urandom_range(0, 16)] ^= 1'b1;
      return cw;
   endfunction

   // -----------------------------------------------------------------------
   // Monitor / scoreboard
   // -----------------------------------------------------------------------
   int   cyc      = 0;
   logic m_idle   = 1'b1;
   logic m_rr     = 1'b0;
   int   m_cnt0   = 0;
   int   m_cnt1   = 0;
   logic holding  = 1'b0;
   exp_t held;
   exp_t e;
   int   acc_cyc  = -100;
   int   inc_cyc  = -100;
   logic inc_ch   = 1'b0;
   logic inc_corr = 1'b0;
   logic g;
   logic acc;
   logic acc_id;

   always @(negedge clk) begin
      cyc++;
      chk("corr_cnt0", 32'(corr_cnt0), 32'(m_cnt0));
      chk("corr_cnt1", 32'(corr_cnt1), 32'(m_cnt1));
      if (!reset_n) begin
         chk("ready_in_reset", 32'({in1_ready, in0_ready}), 32'd0);
         sb_q.delete();
         m_idle  = 1'b1;
         m_rr    = 1'b0;
         holding = 1'b0;
         m_cnt0  = 0;
         m_cnt1  = 0;
         acc_cyc = -100;
         inc_cyc = -100;
      end else begin
         chk("ready_exclusive", 32'(in0_ready & in1_ready), 32'd0);
         acc = 1'b0;
         if (m_idle) begin
            if (in0_valid || in1_valid) begin
               g = (in0_valid && in1_valid) ? m_rr : in1_valid;
               chk("grant", 32'({in1_ready, in0_ready}), g ? 32'd2 : 32'd1);
               acc = in0_ready | in1_ready;
            end else begin
               chk("ready_no_valid", 32'({in1_ready, in0_ready}), 32'd0);
            end
         end else begin
            chk("ready_while_busy", 32'({in1_ready, in0_ready}), 32'd0);
         end

         if (acc) begin
            acc_id = in1_ready & ~in0_ready;
            e = ref_dec(acc_id ? in1_codeword : in0_codeword, acc_id);
            sb_q.push_back(e);
            grant_q.push_back(int'(acc_id));
            m_rr     = ~acc_id;
            acc_cyc  = cyc;
            inc_cyc  = cyc + 1;
            inc_ch   = acc_id;
            inc_corr = e.corr;
         end

         if (out_valid) begin
            if (!holding) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_out: got out_valid=1, required 0 (nothing in flight)");
                  held = '{out_data, out_id, out_syn, out_corr, out_unc};
               end else begin
                  held = sb_q.pop_front();
                  chk("latency", 32'(cyc), 32'(acc_cyc + 2));
               end
               holding = 1'b1;
            end
            chk("out_data", 32'(out_data), 32'(held.data));
            chk("out_id",   32'(out_id),   32'(held.id));
            chk("out_syn",  32'(out_syn),  32'(held.syn));
            chk("out_corr", 32'(out_corr), 32'(held.corr));
            chk("out_unc",  32'(out_unc),  32'(held.unc));
            if (out_ready) begin
               holding = 1'b0;
               m_idle  = 1'b1;
            end
         end else begin
            if (holding) begin
               n_checks++;
               n_errors++;
               $display("FAIL out_dropped: got out_valid=0, required 1 until out_ready");
               holding = 1'b0;
            end
            if (!m_idle && cyc >= acc_cyc + 2) begin
               n_checks++;
               n_errors++;
               $display("FAIL out_missing: got out_valid=0, required 1 at cycle %0d", acc_cyc + 2);
            end
         end

         if (acc) m_idle = 1'b0;

         if (cnt_clr) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
         end else if (cyc == inc_cyc && inc_corr) begin
            if (!inc_ch && m_cnt0 < CNT_MAX) m_cnt0++;
            if ( inc_ch && m_cnt1 < CNT_MAX) m_cnt1++;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Stimulus
   // -----------------------------------------------------------------------
   task automatic send(input logic ch, input logic [16:0] cw, input logic clr_in_dec);
      logic got = 1'b0;
      @(posedge clk); #1;
      if (ch) begin
         in1_valid = 1'b1; in1_codeword = cw;
      end else begin
         in0_valid = 1'b1; in0_codeword = cw;
      end
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         got = ch ? in1_ready : in0_ready;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got no ready on ch%0d, required ready within 20 cycles", ch);
      end
      @(posedge clk); #1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      if (clr_in_dec) begin
         cnt_clr = 1'b1;
         @(posedge clk); #1;
         cnt_clr = 1'b0;
         chk("clr_priority", 32'(ch ? corr_cnt1 : corr_cnt0), 32'd0);
      end
   endtask

   task automatic expect_out(input logic [11:0] d, input logic [4:0] s, input logic c,
                             input logic u, input logic id);
      logic seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("dir_valid", 32'(seen), 32'd1);
      if (seen) begin
         chk("dir_data", 32'(out_data), 32'(d));
         chk("dir_syn",  32'(out_syn),  32'(s));
         chk("dir_corr", 32'(out_corr), 32'(c));
         chk("dir_unc",  32'(out_unc),  32'(u));
         chk("dir_id",   32'(out_id),   32'(id));
      end
   endtask

   task automatic drain();
      logic done = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         @(posedge clk); #2;
         done = (sb_q.size() == 0) && !out_valid;
      end
      chk("drain", 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic done;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_id",    32'(out_id),    32'd0);
      chk("rst_out_syn",   32'(out_syn),   32'd0);
      chk("rst_out_corr",  32'(out_corr),  32'd0);
      chk("rst_out_unc",   32'(out_unc),   32'd0);
      chk("rst_cnt0",      32'(corr_cnt0), 32'd0);
      chk("rst_cnt1",      32'(corr_cnt1), 32'd0);
      chk("rst_ready",     32'({in1_ready, in0_ready}), 32'd0);
      reset_n = 1'b1;

      // Clean codeword
      send(1'b0, 17'h00000, 1'b0);
      expect_out(12'h000, 5'd0, 1'b0, 1'b0, 1'b0);
      drain();

      // Single-bit correction on channel 1
      send(1'b1, 17'h02000, 1'b0);
      expect_out(12'h000, 5'd14, 1'b1, 1'b0, 1'b1);
      chk("dir_cnt1", 32'(corr_cnt1), 32'd1);
      drain();

      // Uncorrectable on channel 0
      send(1'b0, 17'h08002, 1'b0);
      expect_out(12'h000, 5'd18, 1'b0, 1'b1, 1'b0);
      chk("dir_cnt0", 32'(corr_cnt0), 32'd0);
      drain();

      // Round-robin under contention, both valid from reset
      do_reset();
      grant_q.delete();
      in0_valid = 1'b1; in0_codeword = rand_cw();
      in1_valid = 1'b1; in1_codeword = rand_cw();
      reset_n = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(posedge clk); #2;
         done = (grant_q.size() >= 4);
      end
      chk("rr_grants_seen", 32'(done), 32'd1);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      if (done) begin
         chk("rr_grant0", 32'(grant_q[0]), 32'd0);
         chk("rr_grant1", 32'(grant_q[1]), 32'd1);
         chk("rr_grant2", 32'(grant_q[2]), 32'd0);
         chk("rr_grant3", 32'(grant_q[3]), 32'd1);
      end
      drain();

      // Backpressure and input stability
      out_ready = 1'b0;
      send(1'b0, corr_cw(), 1'b0);
      in0_valid = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         in0_codeword = rand_cw();
      end
      chk("bp_held", 32'(out_valid), 32'd1);
      in0_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Counter clear priority and saturation (CNT_W = 2)
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      send(1'b0, corr_cw(), 1'b0);
      drain();
      chk("cnt0_one", 32'(corr_cnt0), 32'd1);
      send(1'b0, corr_cw(), 1'b1);
      drain();
      for (int n = 0; n < 5; n++) begin
         send(1'b0, corr_cw(), 1'b0);
         drain();
      end
      chk("cnt0_saturated", 32'(corr_cnt0), 32'd3);

      // Reset while holding a result in OUT
      out_ready = 1'b0;
      send(1'b1, rand_cw(), 1'b0);
      done = 1'b0;
      for (int t = 0; t < 10 && !done; t++) begin
         @(negedge clk);
         done = out_valid;
      end
      chk("rst_mid_reached_out", 32'(done), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1;
      out_ready = 1'b1;

      // Randomized traffic
      for (int t = 0; t < 500; t++) begin
         @(posedge clk); #1;
         in0_valid    = 1'($urandom_range(0, 1));
         in1_valid    = 1'($urandom_range(0, 1));
         in0_codeword = rand_cw();
         in1_codeword = rand_cw();
         out_ready    = ($urandom_range(0, 3) != 0);
         cnt_clr      = ($urandom_range(0, 24) == 0);
      end
      @(posedge clk); #1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ham_dec_arb.md
# ham_dec_arb

Two-requester arbiter and sequencer for the shared (17,12) Hamming single-error-correcting decoder. It accepts 17-bit codewords from two producers over valid/ready handshakes and grants them round-robin into one decoder instance. It registers the corrected 12-bit data, syndrome and error flags, and presents them on one output handshake tagged with the source ID. It sits between the receive-side codeword producers and the data consumer, and keeps per-channel corrected-error statistics.

## Interface
- `CNT_W`, default 8: width of the per-channel corrected-error counters (saturating).
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in0_valid` in 1: channel 0 codeword valid.
- `in0_codeword` in 17: channel 0 codeword.
- `in0_ready` out 1: channel 0 accepted this cycle.
- `in1_valid`, `in1_codeword`, `in1_ready`: same as channel 0, for channel 1.
- `out_valid` out 1: decoded result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 12: corrected data bits.
- `out_id` out 1: source channel of the result.
- `out_syn` out 5: syndrome.
- `out_corr` out 1: a single-bit correction was applied.
- `out_unc` out 1: uncorrectable; syndrome is greater than 17.
- `cnt_clr` in 1: synchronous clear of both counters.
- `corr_cnt0`, `corr_cnt1` out CNT_W: corrected-error counts per channel.

## Operation
- **Bit positions.** Codeword bit `i` is Hamming position `p = i+1`. Parity bits are at positions 1, 2, 4, 8 and 16.
- **Syndrome.** `syn[k]` is the XOR of every codeword bit whose position has bit `k` set, for k = 0..4.
- **Correction.**
  - syn = 0: no change; `corr` = 0, `unc` = 0.
  - syn 1..17: flip bit `syn-1`; `corr` = 1.
  - syn 18..31: no flip; `unc` = 1, `corr` = 0.
- **Data extraction.** `out_data` = {cw[16], cw[14:8], cw[6:4], cw[2]}, taken after correction.
- **FSM states:** IDLE, DEC, OUT.
  - IDLE: if any `inN_valid` is high, grant one channel, assert its `inN_ready` (combinational, this cycle only), capture its codeword and ID, and go to DEC. Otherwise stay in IDLE.
  - DEC: decode the captured codeword, register all result fields, update the counters, go to OUT.
  - OUT: hold `out_valid` = 1 with stable fields. When `out_ready` = 1, go to IDLE.
- **Arbitration.**
  - Round-robin pointer `rr` resets to 0.
  - If both channels are valid, grant channel `rr`. If only one is valid, grant it.
  - On every grant, `rr` becomes the complement of the granted ID.
- **Ready rule.** `inN_ready` is never high outside IDLE, and never for both channels in the same cycle.
- **Counters.**
  - When DEC produces `corr` = 1, increment the granted channel's counter, saturating at 2^CNT_W−1.
  - `unc` does not increment either counter.
  - `cnt_clr` takes priority over a simultaneous increment.

## Timing
- **Reset values:** FSM = IDLE, `rr` = 0, `out_valid` = 0, `out_data` = 0, `out_id` = 0, `out_syn` = 0, `out_corr` = 0, `out_unc` = 0, both counters = 0, both readies = 0.
- **Latency:** codeword accepted at edge N; `out_valid` rises after edge N+2.
- **Throughput:** at most one codeword per 3 cycles, when `out_ready` is held high.
- **Backpressure:** with `out_ready` = 0, the block stays in OUT indefinitely and all outputs stay stable.
- **Input stability:** inputs are sampled only in the accept cycle. Later changes to `inN_codeword` have no effect on the result in flight.
- **Reset mid-operation:** an in-flight result is discarded and `out_valid` drops on the reset edge.
- **Counter visibility:** counter updates are visible in the same cycle `out_valid` rises.

## Structure
- **Shared package `ham_pkg`:**
  - `HAM_N=17`, `HAM_K=12`, `SYN_W=5`.
  - FSM state encoding: IDLE=0, DEC=1, OUT=2.
  - Data-extract function.
- **Sub-module `ham17_dec`:**
  - Purely combinational: codeword in; data, syn, corr and unc out.
  - Performs no error injection.
  - Instantiated once inside `ham_dec_arb`.

## Test plan
- **Clean codeword:** ch0 sends 17'h00000 with `out_ready` = 1. Expect `out_data` = 0, `out_syn` = 0, `out_corr` = 0, `out_id` = 0, and `out_valid` exactly 2 cycles after accept.
- **Single-bit correction:** ch1 sends 17'h02000 (bit 13 flipped). Expect `out_syn` = 5'd14, `out_corr` = 1, `out_data` = 0, and `corr_cnt1` = 1.
- **Uncorrectable:** ch0 sends 17'h08002 (positions 2 and 16 set). Expect `out_syn` = 5'd18, `out_unc` = 1, `out_corr` = 0, and `corr_cnt0` unchanged.
- **Round-robin under contention:** both channels held valid from reset. Expect grants 0, 1, 0, 1 and `inN_ready` never high for both at once.
- **Backpressure and input stability:** hold `out_ready` = 0 for 10 cycles and change `in0_codeword` during that time. Expect all outputs stable, no new accept, and release on `out_ready` = 1.
- **Counter saturation, clear and reset:**
  - With CNT_W = 2, send 5 corrected words; expect the counter to saturate at 3.
  - Assert `cnt_clr` on the same cycle as an increment; expect the counter to read 0.
  - Assert `reset_n` = 0 while in OUT; expect `out_valid` = 0 on the next edge.
